// File: rtl/dual_rail_add_round_key_reg_pkg.sv
// Shared definitions for the dual-rail AddRoundKey register stage:
// widths, FSM encoding, the spacer word and rail-encoding checks.
package dual_rail_add_round_key_reg_pkg;

    localparam int N    = 128;
    localparam int BYTE = 8;
    localparam int NR   = 14;

    localparam logic [N-1:0] SPACER = '0;

    typedef enum logic [1:0] {
        PRE     = 2'd0,
        WAIT_IN = 2'd1,
        EVAL    = 2'd2
    } fsmState_e;

    // True when every T/F pair carries exactly one active rail.
    function automatic logic isComplete(input logic [N-1:0] railT, input logic [N-1:0] railF);
        return &(railT ^ railF);
    endfunction

    // True when any T/F pair has both rails active (never a legal code).
    function automatic logic isIllegal(input logic [N-1:0] railT, input logic [N-1:0] railF);
        return |(railT & railF);
    endfunction

endpackage

// File: rtl/dual_rail_add_round_key_reg_xor2_byte.sv
// Byte-wide dual-rail 2-input XOR cell. A spacer (00) on either operand
// produces a spacer on the output, so precharge propagates through.
module dr_xor2_byte
    import dual_rail_add_round_key_reg_pkg::*;
(
    input  logic [BYTE-1:0] In1_T,
    input  logic [BYTE-1:0] In1_F,
    input  logic [BYTE-1:0] In2_T,
    input  logic [BYTE-1:0] In2_F,
    output logic [BYTE-1:0] Out_T,
    output logic [BYTE-1:0] Out_F
);

    // Monotonic AND-OR form: true rail fires on differing operands,
    // false rail fires on equal operands.
    always_comb begin
        Out_T = (In1_T & In2_F) | (In1_F & In2_T);
        Out_F = (In1_T & In2_T) | (In1_F & In2_F);
    end

endmodule

// File: rtl/dual_rail_add_round_key_reg.sv
// Dual-rail AddRoundKey with a precharged round-state register, a
// valid/ready output handshake, round index tracking and a sticky
// rail-fault flag.
module dual_rail_add_round_key_reg
    import dual_rail_add_round_key_reg_pkg::*;
#(
    parameter int PRECHARGE_CYCLES = 1
)
(
    input  logic         Clk,
    input  logic         Rst_n,
    input  logic         In_Valid,
    output logic         In_Ready,
    input  logic [N-1:0] State_In_T,
    input  logic [N-1:0] State_In_F,
    input  logic [N-1:0] Key_In_T,
    input  logic [N-1:0] Key_In_F,
    output logic         Out_Valid,
    input  logic         Out_Ready,
    output logic [N-1:0] State_Out_T,
    output logic [N-1:0] State_Out_F,
    output logic [3:0]   Round_Idx,
    output logic         Last_Round,
    output logic         Rail_Error
);

    localparam int CW = (PRECHARGE_CYCLES < 2) ? 1 : $clog2(PRECHARGE_CYCLES + 1);
    localparam logic [CW-1:0] PRE_LOAD = CW'(PRECHARGE_CYCLES);
    localparam logic [CW-1:0] PRE_LAST = CW'(1);
    localparam logic [3:0]    LAST_IDX = 4'(NR);

    logic [N-1:0] xorT;
    logic [N-1:0] xorF;
    logic         inComplete;
    logic         inIllegal;
    logic         outComplete;

    fsmState_e    fsmReg;
    logic [CW-1:0] spacerCntReg;

    generate
        for (genvar gi = 0; gi < N / BYTE; gi++) begin : gXorByte
            dr_xor2_byte uXor (
                .In1_T (State_In_T[gi*BYTE +: BYTE]),
                .In1_F (State_In_F[gi*BYTE +: BYTE]),
                .In2_T (Key_In_T[gi*BYTE +: BYTE]),
                .In2_F (Key_In_F[gi*BYTE +: BYTE]),
                .Out_T (xorT[gi*BYTE +: BYTE]),
                .Out_F (xorF[gi*BYTE +: BYTE])
            );
        end
    endgenerate

    // Completion and fault detection on both the incoming word and the held state.
    always_comb begin
        inComplete  = isComplete(State_In_T, State_In_F) && isComplete(Key_In_T, Key_In_F);
        inIllegal   = isIllegal(State_In_T, State_In_F) || isIllegal(Key_In_T, Key_In_F);
        outComplete = isComplete(State_Out_T, State_Out_F);
    end

    // Precharge / capture / handoff sequencing with registered outputs.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            fsmReg       <= PRE;
            spacerCntReg <= PRE_LOAD;
            State_Out_T  <= SPACER;
            State_Out_F  <= SPACER;
            Out_Valid    <= 1'b0;
            In_Ready     <= 1'b0;
            Round_Idx    <= 4'd0;
            Last_Round   <= 1'b0;
            Rail_Error   <= 1'b0;
        end else begin
            case (fsmReg)
                PRE: begin
                    State_Out_T  <= SPACER;
                    State_Out_F  <= SPACER;
                    Out_Valid    <= 1'b0;
                    spacerCntReg <= spacerCntReg - 1'b1;
                    if (spacerCntReg <= PRE_LAST) begin
                        fsmReg   <= WAIT_IN;
                        In_Ready <= 1'b1;
                    end
                end
                WAIT_IN: begin
                    if (In_Valid) begin
                        if (inIllegal) begin
                            Rail_Error <= 1'b1;
                        end else if (inComplete) begin
                            State_Out_T <= xorT;
                            State_Out_F <= xorF;
                            Out_Valid   <= 1'b1;
                            In_Ready    <= 1'b0;
                            Last_Round  <= (Round_Idx == LAST_IDX);
                            fsmReg      <= EVAL;
                        end
                    end
                end
                EVAL: begin
                    // A held pair that is not one-hot can only come from a fault.
                    if (!outComplete) begin
                        Rail_Error <= 1'b1;
                    end
                    if (Out_Ready) begin
                        State_Out_T  <= SPACER;
                        State_Out_F  <= SPACER;
                        Out_Valid    <= 1'b0;
                        Last_Round   <= 1'b0;
                        Round_Idx    <= (Round_Idx == LAST_IDX) ? 4'd0 : Round_Idx + 4'd1;
                        spacerCntReg <= PRE_LOAD;
                        fsmReg       <= PRE;
                    end
                end
                default: begin
                    fsmReg <= PRE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dual_rail_add_round_key_reg.sv
// Directed, table-driven bench for the dual-rail AddRoundKey register.
module tb_dual_rail_add_round_key_reg;

    logic         Clk = 1'b0;
    logic         Rst_n;
    logic         In_Valid;
    logic         In_Ready;
    logic [127:0] State_In_T;
    logic [127:0] State_In_F;
    logic [127:0] Key_In_T;
    logic [127:0] Key_In_F;
    logic         Out_Valid;
    logic         Out_Ready;
    logic [127:0] State_Out_T;
    logic [127:0] State_Out_F;
    logic [3:0]   Round_Idx;
    logic         Last_Round;
    logic         Rail_Error;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [127:0] stT;
        logic [127:0] kT;
        logic [127:0] expT;
    } vec_t;

    vec_t vecs[5];

    dual_rail_add_round_key_reg #(.PRECHARGE_CYCLES(1)) dut (
        .Clk         (Clk),
        .Rst_n       (Rst_n),
        .In_Valid    (In_Valid),
        .In_Ready    (In_Ready),
        .State_In_T  (State_In_T),
        .State_In_F  (State_In_F),
        .Key_In_T    (Key_In_T),
        .Key_In_F    (Key_In_F),
        .Out_Valid   (Out_Valid),
        .Out_Ready   (Out_Ready),
        .State_Out_T (State_Out_T),
        .State_Out_F (State_Out_F),
        .Round_Idx   (Round_Idx),
        .Last_Round  (Last_Round),
        .Rail_Error  (Rail_Error)
    );

    initial forever #5 Clk = ~Clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic driveSpacer();
        State_In_T = '0;
        State_In_F = '0;
        Key_In_T   = '0;
        Key_In_F   = '0;
    endtask

    task automatic driveVec(input int v);
        State_In_T = vecs[v].stT;
        State_In_F = ~vecs[v].stT;
        Key_In_T   = vecs[v].kT;
        Key_In_F   = ~vecs[v].kT;
    endtask

    // Wait (bounded) for In_Ready, present vector v for one edge, check the held state.
    task automatic capture(input int v, input logic [3:0] expRound);
        int n = 0;
        while (!In_Ready && n < 20) begin
            tick();
            n++;
        end
        check("in_ready_before_capture", In_Ready, 1'b1);
        driveVec(v);
        In_Valid = 1'b1;
        tick();
        In_Valid = 1'b0;
        driveSpacer();
        check("cap_out_valid", Out_Valid, 1'b1);
        check("cap_in_ready", In_Ready, 1'b0);
        check("cap_state_t", State_Out_T, vecs[v].expT);
        check("cap_state_f", State_Out_F, ~vecs[v].expT);
        check("cap_round_idx", Round_Idx, expRound);
        check("cap_last_round", Last_Round, (expRound == 4'd14));
        $display("xfer vec=%0d round=%0d state_t=%h last=%0b", v, Round_Idx, State_Out_T, Last_Round);
    endtask

    // Accept the held word and check the spacer and the advanced round index.
    task automatic handoff(input logic [3:0] expRound);
        logic [3:0] nextRound;
        nextRound = (expRound == 4'd14) ? 4'd0 : expRound + 4'd1;
        Out_Ready = 1'b1;
        tick();
        Out_Ready = 1'b0;
        check("ho_out_valid", Out_Valid, 1'b0);
        check("ho_spacer_t", State_Out_T, '0);
        check("ho_spacer_f", State_Out_F, '0);
        check("ho_round_idx", Round_Idx, nextRound);
        check("ho_in_ready_spacer", In_Ready, 1'b0);
        check("ho_last_round", Last_Round, 1'b0);
    endtask

    initial begin
        vecs[0] = '{128'h00112233445566778899aabbccddeeff, 128'h000102030405060708090a0b0c0d0e0f,
                    128'h00102030405060708090a0b0c0d0e0f0};
        vecs[1] = '{128'hffffffffffffffffffffffffffffffff, 128'h0123456789abcdef0123456789abcdef,
                    128'hfedcba9876543210fedcba9876543210};
        vecs[2] = '{128'h00000000000000000000000000000000, 128'ha5a5a5a5a5a5a5a5a5a5a5a5a5a5a5a5,
                    128'ha5a5a5a5a5a5a5a5a5a5a5a5a5a5a5a5};
        vecs[3] = '{128'h3243f6a8885a308d313198a2e0370734, 128'h3243f6a8885a308d313198a2e0370734,
                    128'h00000000000000000000000000000000};
        vecs[4] = '{128'h0f0f0f0f0f0f0f0f0f0f0f0f0f0f0f0f, 128'hf0f0f0f0f0f0f0f0f0f0f0f0f0f0f0f0,
                    128'hffffffffffffffffffffffffffffffff};

        // Reset then idle
        Rst_n     = 1'b0;
        In_Valid  = 1'b0;
        Out_Ready = 1'b0;
        driveSpacer();
        tick();
        tick();
        check("rst_state_t", State_Out_T, '0);
        check("rst_state_f", State_Out_F, '0);
        check("rst_out_valid", Out_Valid, 1'b0);
        check("rst_in_ready", In_Ready, 1'b0);
        check("rst_rail_error", Rail_Error, 1'b0);
        check("rst_round_idx", Round_Idx, 4'd0);
        Rst_n = 1'b1;
        check("pre_in_ready_low", In_Ready, 1'b0);
        tick();
        check("in_ready_after_precharge", In_Ready, 1'b1);

        // Single transfer with 5 cycles of backpressure; In_Valid during EVAL is ignored
        capture(0, 4'd0);
        In_Valid = 1'b1;
        driveVec(1);
        for (int c = 0; c < 5; c++) begin
            tick();
            check("bp_out_valid", Out_Valid, 1'b1);
            check("bp_state_t", State_Out_T, vecs[0].expT);
            check("bp_state_f", State_Out_F, ~vecs[0].expT);
            check("bp_in_ready", In_Ready, 1'b0);
        end
        In_Valid = 1'b0;
        driveSpacer();
        handoff(4'd0);
        tick();
        check("bp_in_ready_returns", In_Ready, 1'b1);

        // Round wrap: transfers 2..16 (rounds 1..14 then 0)
        for (int i = 1; i < 16; i++) begin
            capture(i % 5, 4'(i % 15));
            handoff(4'(i % 15));
        end

        // Faults: incomplete key pair, then illegal key pair
        tick();
        check("flt_in_ready", In_Ready, 1'b1);
        driveVec(0);
        Key_In_T[5] = 1'b0;
        Key_In_F[5] = 1'b0;
        In_Valid = 1'b1;
        tick();
        check("flt00_no_capture", Out_Valid, 1'b0);
        check("flt00_no_error", Rail_Error, 1'b0);
        check("flt00_still_ready", In_Ready, 1'b1);
        Key_In_T[5] = 1'b1;
        Key_In_F[5] = 1'b1;
        tick();
        check("flt11_no_capture", Out_Valid, 1'b0);
        check("flt11_error", Rail_Error, 1'b1);
        check("flt11_still_ready", In_Ready, 1'b1);
        In_Valid = 1'b0;
        driveSpacer();
        tick();
        tick();
        tick();
        check("flt_error_sticky", Rail_Error, 1'b1);

        // Legal capture after the fault, then reset in the middle of EVAL
        capture(2, 4'd1);
        check("flt_error_sticky_eval", Rail_Error, 1'b1);
        #2;
        Rst_n = 1'b0;
        #1;
        check("mid_rst_state_t", State_Out_T, '0);
        check("mid_rst_state_f", State_Out_F, '0);
        check("mid_rst_out_valid", Out_Valid, 1'b0);
        check("mid_rst_round_idx", Round_Idx, 4'd0);
        check("mid_rst_rail_error", Rail_Error, 1'b0);
        check("mid_rst_in_ready", In_Ready, 1'b0);
        tick();
        Rst_n = 1'b1;
        check("mid_rst_pre", In_Ready, 1'b0);
        tick();
        check("mid_rst_ready_again", In_Ready, 1'b1);
        capture(4, 4'd0);
        handoff(4'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
